// File: rtl/alu_ctrl.sv
// alu_ctrl: sequences one parsed add/sub operation at a time onto the 32-bit
// ALU. It latches the operands, pulses alu_start, and waits for alu_done under
// a timeout. The result and its flags are then held on a valid/ready port
// until the result is accepted.
module alu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        parser_done,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        operator,
    input  logic        data_type,
    output logic        ctrl_busy,
    output logic        alu_start,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_operator,
    output logic        alu_data_type,
    input  logic        alu_done,
    input  logic [31:0] alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_ovf,
    output logic        res_err,
    output logic [15:0] op_cnt
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [TW-1:0] timer_r;

    // Overflow/carry/borrow flag from the latched operands and the ALU result.
    // Unsigned: carry out of an add shows as a wrapped (smaller) result, and a
    // subtract borrows when the minuend is below the subtrahend. Signed: the
    // result sign disagrees with the operand signs that make overflow possible.
    function automatic logic calc_ovf(
        input logic [31:0] op_a,
        input logic [31:0] op_b,
        input logic [31:0] r,
        input logic        sub,
        input logic        sgn
    );
        logic v;
        case ({sgn, sub})
            2'b00:   v = (r < op_a);
            2'b01:   v = (op_a < op_b);
            2'b10:   v = (op_a[31] == op_b[31]) && (r[31] != op_a[31]);
            2'b11:   v = (op_a[31] != op_b[31]) && (r[31] != op_a[31]);
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    // Next-state decode; alu_done takes priority over the final timer cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (parser_done) begin
                    state_nxt_s = S_ISSUE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ISSUE: state_nxt_s = S_WAIT;
            S_WAIT: begin
                if (alu_done) begin
                    state_nxt_s = S_RESP;
                end else if (timer_r == T_LAST) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register; the status outputs are registered from the next state
    // so that they line up with the state they describe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r   <= S_IDLE;
            ctrl_busy <= 1'b0;
            alu_start <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ctrl_busy <= (state_nxt_s != S_IDLE);
            alu_start <= (state_nxt_s == S_ISSUE);
            res_valid <= (state_nxt_s == S_RESP);
        end
    end

    // Datapath: operand latch, wait timer, result capture and handshake count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            alu_a         <= 32'd0;
            alu_b         <= 32'd0;
            alu_operator  <= 1'b0;
            alu_data_type <= 1'b0;
            timer_r       <= '0;
            res_data      <= 32'd0;
            res_ovf       <= 1'b0;
            res_err       <= 1'b0;
            op_cnt        <= 16'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (parser_done) begin
                        alu_a         <= a;
                        alu_b         <= b;
                        alu_operator  <= operator;
                        alu_data_type <= data_type;
                    end
                end
                S_ISSUE: timer_r <= '0;
                S_WAIT: begin
                    if (alu_done) begin
                        res_data <= alu_out;
                        res_ovf  <= calc_ovf(alu_a, alu_b, alu_out,
                                             alu_operator, alu_data_type);
                        res_err  <= 1'b0;
                    end else if (timer_r == T_LAST) begin
                        res_data <= 32'd0;
                        res_ovf  <= 1'b0;
                        res_err  <= 1'b1;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        op_cnt <= op_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing controller between the expression parser and the 32-bit add/sub ALU. Accepts one parsed operation at a time, launches it on the ALU with a single-cycle start pulse, and waits for `alu_done` under a timeout. It then returns the result with overflow/borrow and error flags over a valid/ready result port. Only one operation is in flight at a time; `ctrl_busy` back-pressures the parser.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum number of WAIT cycles allowed for `alu_done`; must be ≥ 2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `parser_done`  in  1  operation valid from the parser; sampled only in IDLE.
- `a`, `b`  in  32 each  operands.
- `operator`  in  1  0 = add, 1 = subtract (a − b).
- `data_type`  in  1  0 = unsigned, 1 = signed (two's complement).
- `ctrl_busy`  out  1  high in every state except IDLE.
- `alu_start`  out  1  one-cycle launch pulse to the ALU.
- `alu_a`, `alu_b`  out  32 each  latched operands driven to the ALU.
- `alu_operator`, `alu_data_type`  out  1 each  latched controls to the ALU.
- `alu_done`  in  1  ALU completion; honoured only in WAIT.
- `alu_out`  in  32  ALU result, valid while `alu_done` = 1.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  32  captured result; 0 on timeout.
- `res_ovf`  out  1  signed overflow or unsigned carry/borrow.
- `res_err`  out  1  timeout occurred.
- `op_cnt`  out  16  count of completed result handshakes; wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if `parser_done` = 1, latch `a`, `b`, `operator` and `data_type` into the `alu_*` registers, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: `alu_start` = 1 for exactly this cycle. Clear the timer, then go to WAIT.
- WAIT, with `alu_done` = 1:
  - capture `alu_out` into `res_data`;
  - compute `res_ovf`;
  - set `res_err` = 0;
  - go to RESP.
- WAIT, with `alu_done` = 0:
  - if timer = TIMEOUT−1: set `res_data` = 0, `res_ovf` = 0, `res_err` = 1, and go to RESP;
  - otherwise increment the timer.
- RESP: `res_valid` = 1. `res_data`, `res_ovf` and `res_err` are held stable until `res_ready` = 1. On the handshake cycle: go to IDLE and increment `op_cnt`, for both error and normal results.
- Overflow rules. They use the latched operands A and B and the result R:
  - unsigned add: R < A;
  - unsigned sub: A < B;
  - signed add: A[31] == B[31] && R[31] != A[31];
  - signed sub: A[31] != B[31] && R[31] != A[31].
- `parser_done` is ignored outside IDLE. Operands are not re-latched while busy.
- `alu_done` is ignored outside WAIT, including a stale `alu_done` that arrives after a timeout.
- If `alu_done` is asserted in the cycle the timer reaches TIMEOUT−1, `alu_done` wins: normal result, no error.

## Timing
- Reset (`n_rst` = 0, asynchronous):
  - state goes to IDLE immediately;
  - all outputs are 0: `ctrl_busy`, `alu_start`, `alu_*`, `res_*`, `op_cnt`, and the timer.
- Reset mid-operation aborts the operation: `alu_start` and `res_valid` drop immediately, and no handshake is counted.
- Cycle n: `parser_done` is sampled in IDLE.
  - n+1: ISSUE, `alu_start` = 1, `ctrl_busy` = 1.
  - n+2: first WAIT cycle.
  - If `alu_done` arrives in cycle k ≥ n+2, `res_valid` = 1 from k+1.
  - Minimum latency from `parser_done` to `res_valid` is 3 cycles.
- Timeout: with no `alu_done`, WAIT lasts exactly TIMEOUT cycles. `res_valid` with `res_err` = 1 appears at n+2+TIMEOUT.
- Throughput: the handshake in cycle h returns the FSM to IDLE at h+1. A new `parser_done` is accepted at h+1, so the minimum issue interval is 4 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold `n_rst` = 0 for 3 cycles with random inputs → every output is 0 and `ctrl_busy` = 0.
- Signed subtract: a=123, b=456, operator=1, data_type=1, `parser_done` pulse. The ALU model returns 0xFFFFFEB3 two cycles after `alu_start`. Expected:
  - `alu_start` high exactly one cycle;
  - `res_data` = 0xFFFFFEB3, `res_ovf` = 0, `res_err` = 0;
  - `op_cnt` = 1 after the handshake.
  - Repeat with data_type=0 → `res_ovf` = 1 (borrow).
- Signed add overflow: 0x7FFFFFFF + 0x00000001, data_type=1, ALU returns 0x80000000 → `res_ovf` = 1.
  - Unsigned add 0xFFFFFFFF + 2 with ALU result 0x00000001 → `res_ovf` = 1.
- Timeout: TIMEOUT=16, the ALU never asserts `alu_done`. Expected:
  - `res_valid` at n+18 with `res_err` = 1 and `res_data` = 0;
  - a late `alu_done` pulse in RESP has no effect on `res_data`.
- Back-pressure: hold `res_ready` = 0 for 5 cycles and pulse `parser_done` with new operands during RESP. Expected:
  - `res_*` stay stable;
  - `alu_a` is unchanged;
  - no second `alu_start`;
  - `op_cnt` increments only once.
- Reset mid-WAIT: assert `n_rst` = 0 during WAIT, release it, then issue a=5, b=3, add, unsigned. Expected:
  - outputs clear immediately on reset;
  - the new operation completes normally with `res_data` = 8;
  - `op_cnt` = 1.
